// File: rtl/pc_sequencer_pkg.sv
// Shared widths, state encoding and redirect bundle for the PC sequencer.
// Also provides the offset sign-extension helper used by the next-PC adder.
package pc_sequencer_pkg;

  localparam int PC_WIDTH     = 15;
  localparam int INSTR_WIDTH  = 16;
  localparam int OFFSET_WIDTH = 8;

  typedef logic [PC_WIDTH-1:0]     pc_t;
  typedef logic [INSTR_WIDTH-1:0]  instr_t;
  typedef logic [OFFSET_WIDTH-1:0] off_t;

  localparam pc_t RESET_VECTOR_DEFAULT = 15'h0000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DELIVER = 3'd2,
    ST_RESOLVE = 3'd3,
    ST_HALTED  = 3'd4
  } seq_state_e;

  // Control-flow outcome from execute; the jump target is already cut to PC width.
  typedef struct packed {
    logic jump_sel;
    logic branch_sel;
    off_t branch_offset;
    pc_t  jump_target;
  } redirect_t;

  function automatic pc_t sext_offset(input off_t o);
    return pc_t'({{(PC_WIDTH-OFFSET_WIDTH){o[OFFSET_WIDTH-1]}}, o});
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch / decode / redirect signal bundle around the PC sequencer.
// master = sequencer side, slave = memory, decode and execute side.
interface pc_sequencer_if;
  import pc_sequencer_pkg::*;

  logic       memReq;
  pc_t        memAddr;
  logic       memAck;
  instr_t     memData;
  logic       instrValid;
  instr_t     instr;
  pc_t        instrPC;
  logic       instrReady;
  logic       redirectValid;
  logic       branchSel;
  logic       jumpSel;
  off_t       branchOffset;
  instr_t     jumpAddress;
  logic       halt;
  logic       restart;
  pc_t        pcOut;
  logic [2:0] seqState;

  modport master (
    output memReq, memAddr, instrValid, instr, instrPC, pcOut, seqState,
    input  memAck, memData, instrReady, redirectValid, branchSel, jumpSel,
           branchOffset, jumpAddress, halt, restart
  );

  modport slave (
    input  memReq, memAddr, instrValid, instr, instrPC, pcOut, seqState,
    output memAck, memData, instrReady, redirectValid, branchSel, jumpSel,
           branchOffset, jumpAddress, halt, restart
  );

endinterface

// File: rtl/pc_sequencer_next_pc_calc.sv
// Combinational next-PC selection: jump beats branch beats sequential.
// All arithmetic is PC-width and wraps naturally.
module next_pc_calc
  import pc_sequencer_pkg::*;
(
  input  pc_t       instr_pc,
  input  redirect_t redir,
  output pc_t       next_pc
);

  always_comb begin
    next_pc = instr_pc + pc_t'(1);
    if (redir.jump_sel)
      next_pc = redir.jump_target;
    else if (redir.branch_sel)
      next_pc = instr_pc + sext_offset(redir.branch_offset);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Single-issue instruction fetch sequencer: IDLE -> FETCH -> DELIVER -> RESOLVE,
// with a HALTED park state left only via restart. All outputs are registered.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter pc_t RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       memReq,
  output pc_t        memAddr,
  input  logic       memAck,
  input  instr_t     memData,
  output logic       instrValid,
  output instr_t     instr,
  output pc_t        instrPC,
  input  logic       instrReady,
  input  logic       redirectValid,
  input  logic       branchSel,
  input  logic       jumpSel,
  input  off_t       branchOffset,
  input  instr_t     jumpAddress,
  input  logic       halt,
  input  logic       restart,
  output pc_t        pcOut,
  output logic [2:0] seqState
);

  seq_state_e state_q, state_d;
  pc_t        pc_q, pc_d;
  instr_t     instr_q, instr_d;
  pc_t        instr_pc_q, instr_pc_d;
  logic       mem_req_q, mem_req_d;
  logic       instr_valid_q, instr_valid_d;

  redirect_t  redir;
  pc_t        next_pc;
  logic       unused_jump_msb;

  assign redir.jump_sel      = jumpSel;
  assign redir.branch_sel    = branchSel;
  assign redir.branch_offset = branchOffset;
  assign redir.jump_target   = jumpAddress[PC_WIDTH-1:0];
  assign unused_jump_msb     = jumpAddress[INSTR_WIDTH-1];

  next_pc_calc u_next_pc (
    .instr_pc (instr_pc_q),
    .redir    (redir),
    .next_pc  (next_pc)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    unique case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: if (memAck) begin
        instr_d    = memData;
        instr_pc_d = pc_q;
        state_d    = ST_DELIVER;
      end
      ST_DELIVER: if (instrReady) state_d = ST_RESOLVE;
      // halt only counts together with the redirect that resolves the instruction
      ST_RESOLVE: if (redirectValid) begin
        pc_d    = next_pc;
        state_d = halt ? ST_HALTED : ST_FETCH;
      end
      ST_HALTED: if (restart) begin
        pc_d    = RESET_VECTOR;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Outputs follow the next state so they are valid as the state is entered.
    mem_req_d     = (state_d == ST_FETCH);
    instr_valid_d = (state_d == ST_DELIVER);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_VECTOR;
      instr_q       <= '0;
      instr_pc_q    <= RESET_VECTOR;
      mem_req_q     <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      mem_req_q     <= mem_req_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign memReq     = mem_req_q;
  assign memAddr    = pc_q;
  assign pcOut      = pc_q;
  assign instrValid = instr_valid_q;
  assign instr      = instr_q;
  assign instrPC    = instr_pc_q;
  assign seqState   = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential fetch, branch/jump/wrap,
// stalls, halt/restart and asynchronous reset mid-fetch.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_VECTOR(15'h0000)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .memReq        (bus.memReq),
    .memAddr       (bus.memAddr),
    .memAck        (bus.memAck),
    .memData       (bus.memData),
    .instrValid    (bus.instrValid),
    .instr         (bus.instr),
    .instrPC       (bus.instrPC),
    .instrReady    (bus.instrReady),
    .redirectValid (bus.redirectValid),
    .branchSel     (bus.branchSel),
    .jumpSel       (bus.jumpSel),
    .branchOffset  (bus.branchOffset),
    .jumpAddress   (bus.jumpAddress),
    .halt          (bus.halt),
    .restart       (bus.restart),
    .pcOut         (bus.pcOut),
    .seqState      (bus.seqState)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step3();
    repeat (3) @(negedge clk);
  endtask

  task automatic set_redir(input logic j, input logic b, input logic [7:0] off, input logic [15:0] ja);
    bus.jumpSel      = j;
    bus.branchSel    = b;
    bus.branchOffset = off;
    bus.jumpAddress  = ja;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    bus.memAck = 0; bus.memData = '0; bus.instrReady = 0; bus.redirectValid = 0;
    bus.halt = 0; bus.restart = 0;
    set_redir(0, 0, 8'h00, 16'h0000);
    #12;
    chk("rst_state",  bus.seqState,   0);
    chk("rst_pc",     bus.pcOut,      0);
    chk("rst_memreq", bus.memReq,     0);
    chk("rst_ivalid", bus.instrValid, 0);
    chk("rst_instr",  bus.instr,      0);
    chk("rst_ipc",    bus.instrPC,    0);

    // release at a negedge: one IDLE cycle, then FETCH
    @(negedge clk); reset_n = 1'b1; #1;
    chk("idle_state",  bus.seqState, 0);
    chk("idle_memreq", bus.memReq,   0);
    @(negedge clk);
    chk("first_fetch_req",  bus.memReq,   1);
    chk("first_fetch_addr", bus.memAddr,  0);

    // everything tied ready: 3-cycle period, sequential addresses
    bus.memAck = 1; bus.instrReady = 1; bus.redirectValid = 1; bus.memData = 16'hA5C3;
    for (int k = 0; k < 3; k++) begin
      chk("seq_req",  bus.memReq,  1);
      chk("seq_addr", bus.memAddr, k);
      @(negedge clk);
      chk("seq_deliver", bus.seqState, 2);
      chk("seq_ipc",     bus.instrPC,  k);
      chk("seq_instr",   bus.instr,    16'hA5C3);
      @(negedge clk);
      chk("seq_resolve", bus.seqState, 3);
      chk("seq_noreq",   bus.memReq,   0);
      @(negedge clk);
    end
    chk("seq_addr3", bus.memAddr, 3);

    set_redir(1, 0, 8'h00, 16'h0010); step3();
    chk("jump_0010", bus.memAddr, 15'h0010);
    set_redir(0, 1, 8'hFC, 16'h0000); step3();
    chk("branch_neg", bus.memAddr, 15'h000C);
    set_redir(1, 0, 8'h00, 16'h0010); step3();
    chk("jump_0010b", bus.memAddr, 15'h0010);
    set_redir(0, 1, 8'h05, 16'h0000); step3();
    chk("branch_pos", bus.memAddr, 15'h0015);
    set_redir(1, 1, 8'h05, 16'hC123); step3();
    chk("jump_prio", bus.memAddr, 15'h4123);
    set_redir(1, 0, 8'h00, 16'h7FFF); step3();
    chk("jump_7fff", bus.memAddr, 15'h7FFF);
    set_redir(0, 0, 8'h00, 16'h0000); step3();
    chk("wrap_inc", bus.memAddr, 15'h0000);
    set_redir(0, 1, 8'hFF, 16'h0000); step3();
    chk("wrap_branch", bus.memAddr, 15'h7FFF);

    // fetch stall: ack low 5 cycles, memReq high 6 cycles
    bus.memAck = 0; bus.instrReady = 0; bus.redirectValid = 0; bus.halt = 1;
    set_redir(0, 0, 8'h00, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      chk("stall_req",  bus.memReq,   1);
      chk("stall_addr", bus.memAddr,  15'h7FFF);
      @(negedge clk);
    end
    bus.memAck = 1; bus.memData = 16'h5A5A;
    chk("stall_req6", bus.memReq, 1);
    @(negedge clk);
    bus.memData = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      chk("hold_valid", bus.instrValid, 1);
      chk("hold_instr", bus.instr,      16'h5A5A);
      chk("hold_ipc",   bus.instrPC,    15'h7FFF);
      @(negedge clk);
    end
    chk("hold_state", bus.seqState, 2);
    bus.instrReady = 1; bus.halt = 0;
    @(negedge clk);
    chk("resolve_entry", bus.seqState,   3);
    chk("resolve_novld", bus.instrValid, 0);
    bus.halt = 1;
    @(negedge clk);
    chk("halt_no_redir", bus.seqState, 3);

    // halt with redirect: park at the jump target
    bus.redirectValid = 1; set_redir(1, 0, 8'h00, 16'h1234);
    @(negedge clk);
    chk("halted_state", bus.seqState, 4);
    chk("halted_pc",    bus.pcOut,    15'h1234);
    bus.halt = 0;
    repeat (2) @(negedge clk);
    chk("halted_hold",  bus.seqState, 4);
    chk("halted_noreq", bus.memReq,   0);
    chk("halted_novld", bus.instrValid, 0);
    chk("halted_pc2",   bus.pcOut,    15'h1234);
    bus.restart = 1;
    @(negedge clk);
    bus.restart = 0;
    chk("restart_idle", bus.seqState, 0);
    chk("restart_pc",   bus.pcOut,    15'h0000);
    @(negedge clk);
    chk("restart_fetch", bus.memReq,  1);
    chk("restart_addr",  bus.memAddr, 15'h0000);

    // asynchronous reset mid-fetch, then a late ack during IDLE
    bus.memAck = 0;
    #2 reset_n = 1'b0;
    #1;
    chk("async_memreq", bus.memReq,   0);
    chk("async_state",  bus.seqState, 0);
    chk("async_instr",  bus.instr,    0);
    bus.memAck = 1;
    @(negedge clk); reset_n = 1'b1; #1;
    chk("late_ack_idle", bus.seqState, 0);
    @(negedge clk);
    chk("late_ack_fetch", bus.seqState,   1);
    chk("late_ack_novld", bus.instrValid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
